mmul_issue_queue: RTL

// - Parametrised successor to the combinational MMUL decoder. Buffers instructions in a FIFO and decodes the head.
// - Enforces register hazards with a scoreboard and issues control words to the systolic array over valid/ready.
// - Sits between the instruction fetch/host interface and the PE array controller.

---
 rtl/mmul_issue_queue_if.sv | 37 +++
 rtl/mmul_issue_queue.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mmul_issue_queue_if.sv
// Handshake bundle between fetch/host, the MMUL issue queue and the PE array controller.
// The queue uses the slave modport; the environment driving it uses master.
interface mmul_issue_queue_if #(
    parameter int REG_W = 3,
    parameter int OP_W  = 2
);
    logic             inst_valid_i;
    logic             inst_ready_o;
    logic [OP_W-1:0]  inst_op_i;
    logic [REG_W-1:0] inst_src1_i;
    logic [REG_W-1:0] inst_src2_i;
    logic [REG_W-1:0] inst_dest_i;
    logic             flush_i;
    logic             iss_valid_o;
    logic             iss_ready_i;
    logic [REG_W-1:0] iss_src1_o;
    logic [REG_W-1:0] iss_src2_o;
    logic             iss_drain_o;
    logic             iss_we_o;
    logic [REG_W-1:0] iss_dest_o;
    logic             wb_valid_i;
    logic [REG_W-1:0] wb_reg_i;

    modport master (
        output inst_valid_i, inst_op_i, inst_src1_i, inst_src2_i, inst_dest_i, flush_i,
               iss_ready_i, wb_valid_i, wb_reg_i,
        input  inst_ready_o, iss_valid_o, iss_src1_o, iss_src2_o, iss_drain_o, iss_we_o,
               iss_dest_o
    );

    modport slave (
        input  inst_valid_i, inst_op_i, inst_src1_i, inst_src2_i, inst_dest_i, flush_i,
               iss_ready_i, wb_valid_i, wb_reg_i,
        output inst_ready_o, iss_valid_o, iss_src1_o, iss_src2_o, iss_drain_o, iss_we_o,
               iss_dest_o
    );
endinterface

// File: rtl/mmul_issue_queue.sv
// MMUL issue queue: instruction FIFO, head decode, register scoreboard, valid/ready issue.
// Define MMUL_PERF_CNT_EN to add saturating per-state cycle counters.
//   state     | meaning
//   IDLE      | FIFO empty, flushing, or dropping an illegal head
//   ISSUE     | control word accepted this cycle
//   STALL_HAZ | head blocked by the scoreboard
//   STALL_BP  | control word offered, array not ready
module mmul_issue_queue #(
    parameter int REG_W      = 3,
    parameter int OP_W       = 2,
    parameter int DEPTH      = 4,
    parameter int OP_MMUL_D  = 0,
    parameter int OP_MMUL_ND = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    mmul_issue_queue_if.slave     bus,
    output logic [2**REG_W-1:0]   busy_o,
    output logic                  err_illegal_o,
    output logic [1:0]            state_o
`ifdef MMUL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_issued_o,
    output logic [CNT_W-1:0]      perf_stall_haz_o,
    output logic [CNT_W-1:0]      perf_stall_bp_o
`endif
);
    localparam int NUM_REGS = 2**REG_W;
    localparam int PTR_W    = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("mmul_issue_queue: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, STALL_HAZ = 2'd2, STALL_BP = 2'd3} state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic [REG_W-1:0] dest;
    } inst_t;

    inst_t                mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       cnt_q, cnt_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic                 err_q, err_d;
    state_e               state_q, state_d;

    inst_t head;
    logic  head_vld, is_d, legal, hazard, iss_valid, drop_ill, issue, pop, push, full;

    assign head     = mem_q[rd_ptr_q];
    assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
    // Flush masks the head so nothing issues or drops in the flush cycle.
    assign head_vld = (cnt_q != '0) && !bus.flush_i;
    assign is_d     = (head.op == OP_W'(OP_MMUL_D));
    assign legal    = is_d || (head.op == OP_W'(OP_MMUL_ND));
    assign hazard   = busy_q[head.src1] || busy_q[head.src2] || (is_d && busy_q[head.dest]);
    assign iss_valid = head_vld && legal && !hazard;
    assign drop_ill = head_vld && !legal;
    assign issue    = iss_valid && bus.iss_ready_i;
    assign pop      = issue || drop_ill;
    assign push     = bus.inst_valid_i && !full && !bus.flush_i;

    assign bus.inst_ready_o = !full;
    assign bus.iss_valid_o  = iss_valid;
    assign bus.iss_src1_o   = iss_valid ? head.src1 : '0;
    assign bus.iss_src2_o   = iss_valid ? head.src2 : '0;
    assign bus.iss_dest_o   = iss_valid ? head.dest : '0;
    assign bus.iss_drain_o  = iss_valid && is_d;
    assign bus.iss_we_o     = iss_valid && is_d;

    assign busy_o        = busy_q;
    assign err_illegal_o = err_q;
    assign state_o       = state_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: bus.inst_op_i, src1: bus.inst_src1_i,
                                 src2: bus.inst_src2_i, dest: bus.inst_dest_i};
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        err_d    = err_q || drop_ill;
        if (bus.flush_i) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        // Clear first so a same-cycle set on the same register wins.
        if (bus.wb_valid_i)  busy_d[bus.wb_reg_i] = 1'b0;
        if (issue && is_d)   busy_d[head.dest]    = 1'b1;
    end

    always_comb begin
        state_d = IDLE;
        if (!head_vld || !legal) state_d = IDLE;
        else if (hazard)         state_d = STALL_HAZ;
        else if (bus.iss_ready_i) state_d = ISSUE;
        else                     state_d = STALL_BP;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

`ifdef MMUL_PERF_CNT_EN
    logic [CNT_W-1:0] perf_issued_q, perf_stall_haz_q, perf_stall_bp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued_q    <= '0;
            perf_stall_haz_q <= '0;
            perf_stall_bp_q  <= '0;
        end else begin
            if (state_q == ISSUE && perf_issued_q != '1)
                perf_issued_q <= perf_issued_q + CNT_W'(1);
            if (state_q == STALL_HAZ && perf_stall_haz_q != '1)
                perf_stall_haz_q <= perf_stall_haz_q + CNT_W'(1);
            if (state_q == STALL_BP && perf_stall_bp_q != '1)
                perf_stall_bp_q <= perf_stall_bp_q + CNT_W'(1);
        end
    end

    assign perf_issued_o    = perf_issued_q;
    assign perf_stall_haz_o = perf_stall_haz_q;
    assign perf_stall_bp_o  = perf_stall_bp_q;
`endif
endmodule
